reg_file_arbiter: RTL and testbench

- Shares one 2-read/1-write 32x32 register file between two requesters: port 0 is the core, port 1 is the debug/loader.
- Round-robin grant, one op per cycle; a registered issue stage drives the register-file ports.
- Read data is captured and returned with a one-cycle response pulse.
- Supports an atomic SWAP (read old value, then write), which locks the register file for two cycles.

---
 rtl/reg_file_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_reg_file_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_arbiter.sv
// Two-requester round-robin arbiter for a shared 2R/1W register file.
// A registered issue stage drives the register-file ports, and an atomic SWAP locks the file for two cycles.
module reg_file_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_Regs,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_op0,
    input  logic [1:0]        req_op1,
    input  logic [ADDR_W-1:0] req_addr_a0,
    input  logic [ADDR_W-1:0] req_addr_a1,
    input  logic [ADDR_W-1:0] req_addr_b0,
    input  logic [ADDR_W-1:0] req_addr_b1,
    input  logic [ADDR_W-1:0] req_waddr0,
    input  logic [ADDR_W-1:0] req_waddr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] resp_data_a,
    output logic [DATA_W-1:0] resp_data_b,
    output logic              Reg_Write,
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [ADDR_W-1:0] R_Addr_B,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    input  logic [DATA_W-1:0] R_Data_A,
    input  logic [DATA_W-1:0] R_Data_B
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SWAP2 = 1'b1
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                iss_valid_q, iss_valid_d;
    logic                iss_id_q, iss_id_d;
    logic [1:0]          iss_op_q, iss_op_d;
    logic [ADDR_W-1:0]   iss_addr_a_q, iss_addr_a_d;
    logic [DATA_W-1:0]   iss_wdata_q, iss_wdata_d;
    logic [DATA_W-1:0]   swap_old_q, swap_old_d;
    logic [1:0]          resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_a_q, resp_data_a_d;
    logic [DATA_W-1:0]   resp_data_b_q, resp_data_b_d;
    logic                reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]   r_addr_a_q, r_addr_a_d;
    logic [ADDR_W-1:0]   r_addr_b_q, r_addr_b_d;
    logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;

    logic                grant_en_s;
    logic [1:0]          ready_s;
    logic                fire_s;
    logic                sel_s;
    logic [1:0]          sel_op_s;
    logic [ADDR_W-1:0]   sel_addr_a_s;
    logic [ADDR_W-1:0]   sel_addr_b_s;
    logic [ADDR_W-1:0]   sel_waddr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [1:0]          iss_onehot_s;

    // Round-robin grant; frozen while a SWAP owns the register file.
    always_comb begin
        grant_en_s = (state_q == ST_RUN) && !(iss_valid_q && (iss_op_q == OP_SWAP));
        ready_s    = 2'b00;
        if (grant_en_s) begin
            case (req_valid)
                2'b01:   ready_s = 2'b01;
                2'b10:   ready_s = 2'b10;
                2'b11:   ready_s = last_grant_q ? 2'b01 : 2'b10;
                default: ready_s = 2'b00;
            endcase
        end else begin
            ready_s = 2'b00;
        end
    end

    assign fire_s       = |ready_s;
    assign sel_s        = ready_s[1];
    assign sel_op_s     = sel_s ? req_op1     : req_op0;
    assign sel_addr_a_s = sel_s ? req_addr_a1 : req_addr_a0;
    assign sel_addr_b_s = sel_s ? req_addr_b1 : req_addr_b0;
    assign sel_waddr_s  = sel_s ? req_waddr1  : req_waddr0;
    assign sel_wdata_s  = sel_s ? req_wdata1  : req_wdata0;
    assign iss_onehot_s = iss_id_q ? 2'b10 : 2'b01;

    // Next-state: SWAP FSM, response capture and issue-stage load.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        iss_valid_d   = 1'b0;
        iss_id_d      = iss_id_q;
        iss_op_d      = iss_op_q;
        iss_addr_a_d  = iss_addr_a_q;
        iss_wdata_d   = iss_wdata_q;
        swap_old_d    = swap_old_q;
        resp_valid_d  = 2'b00;
        resp_data_a_d = resp_data_a_q;
        resp_data_b_d = resp_data_b_q;
        reg_write_d   = 1'b0;
        r_addr_a_d    = r_addr_a_q;
        r_addr_b_d    = r_addr_b_q;
        w_addr_d      = w_addr_q;
        w_data_d      = w_data_q;

        case (state_q)
            ST_RUN: begin
                if (iss_valid_q) begin
                    case (iss_op_q)
                        OP_READ: begin
                            resp_valid_d  = iss_onehot_s;
                            resp_data_a_d = R_Data_A;
                            resp_data_b_d = R_Data_B;
                        end
                        OP_SWAP: begin
                            // Old value is captured now; the write goes out in SWAP2.
                            swap_old_d  = R_Data_A;
                            state_d     = ST_SWAP2;
                            iss_valid_d = 1'b1;
                            w_addr_d    = iss_addr_a_q;
                            w_data_d    = iss_wdata_q;
                            reg_write_d = |iss_addr_a_q;
                        end
                        default: begin
                            resp_valid_d  = iss_onehot_s;
                            resp_data_a_d = {DATA_W{1'b0}};
                            resp_data_b_d = {DATA_W{1'b0}};
                        end
                    endcase
                end else begin
                    iss_valid_d = 1'b0;
                end
            end
            ST_SWAP2: begin
                state_d       = ST_RUN;
                iss_valid_d   = 1'b0;
                resp_valid_d  = iss_onehot_s;
                resp_data_a_d = swap_old_q;
                resp_data_b_d = {DATA_W{1'b0}};
            end
            default: begin
                state_d     = ST_RUN;
                iss_valid_d = 1'b0;
            end
        endcase

        if (fire_s) begin
            last_grant_d = sel_s;
            iss_valid_d  = 1'b1;
            iss_id_d     = sel_s;
            iss_op_d     = sel_op_s;
            iss_addr_a_d = sel_addr_a_s;
            iss_wdata_d  = sel_wdata_s;
            case (sel_op_s)
                OP_READ: begin
                    r_addr_a_d = sel_addr_a_s;
                    r_addr_b_d = sel_addr_b_s;
                end
                OP_WRITE: begin
                    w_addr_d    = sel_waddr_s;
                    w_data_d    = sel_wdata_s;
                    reg_write_d = |sel_waddr_s;
                end
                OP_SWAP: begin
                    r_addr_a_d = sel_addr_a_s;
                end
                OP_NOP: begin
                    reg_write_d = 1'b0;
                end
                default: begin
                    reg_write_d = 1'b0;
                end
            endcase
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // State and output registers; reset discards any in-flight op.
    always_ff @(posedge clk_Regs or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            last_grant_q  <= 1'b1;
            iss_valid_q   <= 1'b0;
            iss_id_q      <= 1'b0;
            iss_op_q      <= OP_NOP;
            iss_addr_a_q  <= {ADDR_W{1'b0}};
            iss_wdata_q   <= {DATA_W{1'b0}};
            swap_old_q    <= {DATA_W{1'b0}};
            resp_valid_q  <= 2'b00;
            resp_data_a_q <= {DATA_W{1'b0}};
            resp_data_b_q <= {DATA_W{1'b0}};
            reg_write_q   <= 1'b0;
            r_addr_a_q    <= {ADDR_W{1'b0}};
            r_addr_b_q    <= {ADDR_W{1'b0}};
            w_addr_q      <= {ADDR_W{1'b0}};
            w_data_q      <= {DATA_W{1'b0}};
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            iss_valid_q   <= iss_valid_d;
            iss_id_q      <= iss_id_d;
            iss_op_q      <= iss_op_d;
            iss_addr_a_q  <= iss_addr_a_d;
            iss_wdata_q   <= iss_wdata_d;
            swap_old_q    <= swap_old_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_a_q <= resp_data_a_d;
            resp_data_b_q <= resp_data_b_d;
            reg_write_q   <= reg_write_d;
            r_addr_a_q    <= r_addr_a_d;
            r_addr_b_q    <= r_addr_b_d;
            w_addr_q      <= w_addr_d;
            w_data_q      <= w_data_d;
        end
    end

    assign req_ready   = ready_s;
    assign resp_valid  = resp_valid_q;
    assign resp_data_a = resp_data_a_q;
    assign resp_data_b = resp_data_b_q;
    assign Reg_Write   = reg_write_q;
    assign R_Addr_A    = r_addr_a_q;
    assign R_Addr_B    = r_addr_b_q;
    assign W_Addr      = w_addr_q;
    assign W_Data      = w_data_q;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed scoreboard bench for reg_file_arbiter with a behavioural 32x32 register file.
module tb_reg_file_arbiter;

    logic        clk_Regs;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_op0, req_op1;
    logic [4:0]  req_addr_a0, req_addr_a1, req_addr_b0, req_addr_b1;
    logic [4:0]  req_waddr0, req_waddr1;
    logic [31:0] req_wdata0, req_wdata1;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data_a, resp_data_b;
    logic        Reg_Write;
    logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
    logic [31:0] W_Data, R_Data_A, R_Data_B;

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [31:0] rf [32];
    logic        rf_init = 1'b0;

    reg_file_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk_Regs   (clk_Regs),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_addr_a0(req_addr_a0),
        .req_addr_a1(req_addr_a1),
        .req_addr_b0(req_addr_b0),
        .req_addr_b1(req_addr_b1),
        .req_waddr0 (req_waddr0),
        .req_waddr1 (req_waddr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .resp_valid (resp_valid),
        .resp_data_a(resp_data_a),
        .resp_data_b(resp_data_b),
        .Reg_Write  (Reg_Write),
        .R_Addr_A   (R_Addr_A),
        .R_Addr_B   (R_Addr_B),
        .W_Addr     (W_Addr),
        .W_Data     (W_Data),
        .R_Data_A   (R_Data_A),
        .R_Data_B   (R_Data_B)
    );

    initial clk_Regs = 1'b0;
    always #5 clk_Regs = ~clk_Regs;

    function automatic logic [31:0] init_val(input int i);
        if (i == 0)      return 32'h0000_0000;
        else if (i == 3) return 32'h1234_5678;
        else if (i == 5) return 32'h0000_0011;
        else             return 32'h1000_0000 + 32'(i);
    endfunction

    // Behavioural register file: preload once, then commit writes on the rising edge.
    always @(posedge clk_Regs) begin
        if (!rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
            rf_init <= 1'b1;
        end else if (Reg_Write) begin
            rf[W_Addr] <= W_Data;
        end
    end

    assign R_Data_A = rf[R_Addr_A];
    assign R_Data_B = rf[R_Addr_B];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [1:0] vld, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.vld = vld;
        e.a   = a;
        e.b   = b;
        sb_q.push_back(e);
    endtask

    task automatic next_cyc();
        @(posedge clk_Regs);
        #1;
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [4:0] a,
                           input logic [4:0] b, input logic [4:0] wa, input logic [31:0] wd);
        if (id == 0) begin
            req_op0 = op; req_addr_a0 = a; req_addr_b0 = b; req_waddr0 = wa; req_wdata0 = wd;
        end else begin
            req_op1 = op; req_addr_a1 = a; req_addr_b1 = b; req_waddr1 = wa; req_wdata1 = wd;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk_Regs);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_Regs);
        rst_n = 1'b1;
    endtask

    // Monitor: every response pulse is matched against the head of the scoreboard.
    always @(negedge clk_Regs) begin
        if (resp_valid != 2'b00) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL resp_unexpected: got resp_valid=%b expected none at %0t", resp_valid, $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_valid", 32'(resp_valid), 32'(mon_e.vld));
                chk("resp_data_a", resp_data_a, mon_e.a);
                chk("resp_data_b", resp_data_b, mon_e.b);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        set_req(0, 2'b11, 5'd0, 5'd0, 5'd0, 32'h0);
        set_req(1, 2'b11, 5'd0, 5'd0, 5'd0, 32'h0);
        repeat (3) @(negedge clk_Regs);
        chk("rst_reg_write", 32'(Reg_Write), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data_a", resp_data_a, 32'd0);
        chk("rst_r_addr_a", 32'(R_Addr_A), 32'd0);
        chk("rst_w_data", W_Data, 32'd0);
        rst_n = 1'b1;

        // Single READ from requester 0.
        next_cyc();
        set_req(0, 2'b00, 5'd3, 5'd0, 5'd0, 32'h0);
        req_valid = 2'b01;
        @(negedge clk_Regs);
        chk("t1_ready", 32'(req_ready), 32'd1);
        push(2'b01, 32'h1234_5678, 32'h0);
        next_cyc();
        req_valid = 2'b00;
        @(negedge clk_Regs);
        chk("t1_r_addr_a", 32'(R_Addr_A), 32'd3);
        chk("t1_reg_write", 32'(Reg_Write), 32'd0);
        repeat (4) next_cyc();

        // Both requesters stream READs: strict alternation starting at 0.
        pulse_reset();
        next_cyc();
        set_req(0, 2'b00, 5'd1, 5'd2, 5'd0, 32'h0);
        set_req(1, 2'b00, 5'd4, 5'd6, 5'd0, 32'h0);
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_Regs);
            if (i % 2 == 0) begin
                chk("t2_ready", 32'(req_ready), 32'd1);
                push(2'b01, 32'h1000_0001, 32'h1000_0002);
            end else begin
                chk("t2_ready", 32'(req_ready), 32'd2);
                push(2'b10, 32'h1000_0004, 32'h1000_0006);
            end
            next_cyc();
        end
        req_valid = 2'b00;
        repeat (3) next_cyc();

        // WRITE x7 from requester 1, then READ x7 from requester 0 right behind it.
        set_req(1, 2'b01, 5'd0, 5'd0, 5'd7, 32'hDEAD_BEEF);
        req_valid = 2'b10;
        @(negedge clk_Regs);
        chk("t3_ready_w", 32'(req_ready), 32'd2);
        push(2'b10, 32'h0, 32'h0);
        next_cyc();
        set_req(0, 2'b00, 5'd7, 5'd0, 5'd0, 32'h0);
        req_valid = 2'b01;
        @(negedge clk_Regs);
        chk("t3_ready_r", 32'(req_ready), 32'd1);
        chk("t3_reg_write", 32'(Reg_Write), 32'd1);
        chk("t3_w_addr", 32'(W_Addr), 32'd7);
        push(2'b01, 32'hDEAD_BEEF, 32'h0);
        next_cyc();

        // WRITE x0 is suppressed but acknowledged; x0 still reads 0.
        set_req(0, 2'b01, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk_Regs);
        push(2'b01, 32'h0, 32'h0);
        next_cyc();
        set_req(0, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0);
        @(negedge clk_Regs);
        chk("t4_reg_write_x0", 32'(Reg_Write), 32'd0);
        push(2'b01, 32'h0, 32'h0);
        next_cyc();

        // NOP from requester 1 leaves last_grant at 1.
        set_req(1, 2'b11, 5'd0, 5'd0, 5'd0, 32'h0);
        req_valid = 2'b10;
        @(negedge clk_Regs);
        chk("t4_ready_nop", 32'(req_ready), 32'd2);
        push(2'b10, 32'h0, 32'h0);
        next_cyc();

        // SWAP x5 (0x11 -> 0x22) while requester 1 waits to read x5.
        set_req(0, 2'b10, 5'd5, 5'd0, 5'd0, 32'h0000_0022);
        set_req(1, 2'b00, 5'd5, 5'd0, 5'd0, 32'h0);
        req_valid = 2'b11;
        @(negedge clk_Regs);
        chk("t5_ready_swap", 32'(req_ready), 32'd1);
        push(2'b01, 32'h0000_0011, 32'h0);
        next_cyc();
        req_valid = 2'b10;
        @(negedge clk_Regs);
        chk("t5_ready_lock1", 32'(req_ready), 32'd0);
        chk("t5_reg_write_rd", 32'(Reg_Write), 32'd0);
        chk("t5_r_addr_a", 32'(R_Addr_A), 32'd5);
        next_cyc();
        @(negedge clk_Regs);
        chk("t5_ready_lock2", 32'(req_ready), 32'd0);
        chk("t5_reg_write_wr", 32'(Reg_Write), 32'd1);
        chk("t5_w_addr", 32'(W_Addr), 32'd5);
        chk("t5_w_data", W_Data, 32'h0000_0022);
        next_cyc();
        @(negedge clk_Regs);
        chk("t5_ready_after", 32'(req_ready), 32'd2);
        push(2'b10, 32'h0000_0022, 32'h0);
        next_cyc();
        req_valid = 2'b00;
        repeat (4) next_cyc();

        // Reset during SWAP2 of x9: write dropped, no response, arbitration restarts at 0.
        set_req(0, 2'b10, 5'd9, 5'd0, 5'd0, 32'h0000_0099);
        req_valid = 2'b01;
        @(negedge clk_Regs);
        chk("t6_ready_swap", 32'(req_ready), 32'd1);
        next_cyc();
        req_valid = 2'b00;
        next_cyc();
        @(negedge clk_Regs);
        chk("t6_reg_write_swap2", 32'(Reg_Write), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_reg_write_rst", 32'(Reg_Write), 32'd0);
        repeat (2) @(negedge clk_Regs);
        rst_n = 1'b1;
        next_cyc();
        set_req(0, 2'b00, 5'd9, 5'd0, 5'd0, 32'h0);
        set_req(1, 2'b00, 5'd10, 5'd7, 5'd0, 32'h0);
        req_valid = 2'b11;
        @(negedge clk_Regs);
        chk("t6_ready_first", 32'(req_ready), 32'd1);
        push(2'b01, 32'h1000_0009, 32'h0);
        next_cyc();
        @(negedge clk_Regs);
        chk("t6_ready_second", 32'(req_ready), 32'd2);
        push(2'b10, 32'h1000_000A, 32'hDEAD_BEEF);
        next_cyc();
        req_valid = 2'b00;
        repeat (5) next_cyc();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
